ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Performs the request-to-send sequence, then shifts data out on device-generated clock edges.
- Checks the device's acknowledge bit.
- Sits beside the PS2 receiver under the keyboard/paddle control logic and shares the open-drain ps2Clk/ps2Data lines with it.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2Clk is held low before RTS (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: max clk cycles from clock release to end of frame (20 ms at 50 MHz).
- SYNC_STAGES, 2: synchronizer depth on ps2Clk/ps2Data inputs (minimum 2).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- txData  in  8  byte to send; sampled when txStart is accepted
- txStart  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE only
- busy  out  1  high whenever not IDLE; the receiver ignores ps2Data frames while busy
- done  out  1  1-cycle pulse: frame sent and ACK received
- ackError  out  1  1-cycle pulse: ACK bit sampled high
- timeoutError  out  1  1-cycle pulse: TIMEOUT_CYCLES exceeded
- ps2ClkIn  in  1  raw PS/2 clock line level
- ps2DataIn  in  1  raw PS/2 data line level
- ps2ClkLow  out  1  1 = pull PS/2 clock low (open-drain enable); 0 = release
- ps2DataLow  out  1  1 = pull PS/2 data low; 0 = release

Behaviour:
- All outputs are registered.
- Reset values: ready=1, busy=0, done=0, ackError=0, timeoutError=0, ps2ClkLow=0, ps2DataLow=0, state=IDLE.
- Reset mid-frame releases both lines on the next edge and discards the frame; no error pulse is generated.
- Inputs pass through SYNC_STAGES flops. fallEdge is asserted one cycle when the synchronized clock goes 1->0.
- Latency from the raw falling edge to the new ps2DataLow value is SYNC_STAGES+2 clk cycles (well inside the device's ~40 us low phase).
- IDLE:
  - On txStart=1, latch txData and compute odd parity (parity = ~^txData).
  - Clear the inhibit/timeout counter and bitCount, then go to INHIBIT.
  - txStart while not IDLE is ignored, with no queueing.
- INHIBIT: ps2ClkLow=1, ps2DataLow=0. After INHIBIT_CYCLES cycles, go to RTS.
- RTS: ps2ClkLow=1, ps2DataLow=1 for exactly 1 cycle. Then go to SEND with ps2ClkLow=0 and ps2DataLow held at 1 (this is the start bit).
- SEND: on each fallEdge, increment bitCount (1..11):
  - 1..8: ps2DataLow = ~txData[bitCount-1], LSB first.
  - 9: ps2DataLow = ~parity.
  - 10: ps2DataLow = 0 (stop bit, line released).
  - 11: sample synchronized data. 0 -> go to WAIT_IDLE. 1 -> pulse ackError, go to IDLE.
- WAIT_IDLE: wait until synchronized clock=1 and data=1, then pulse done and go to IDLE.
- Timeout:
  - The counter runs from entry to SEND through WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses timeoutError and goes to IDLE.
  - The timeout takes priority over a simultaneous fallEdge.
- Counter widths are $clog2 of the respective parameter plus 1, so there is no wrap before the compare.
- done, ackError and timeoutError are mutually exclusive; exactly one fires per accepted txStart, except when rst intervenes.
- ready rises in the same cycle as the done/error pulse.

Decomposition:
- Shared package ps2_pkg:
  - State enum: IDLE, INHIBIT, RTS, SEND, WAIT_IDLE.
  - Command constants: CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4.
  - Response constants: RSP_ACK=8'hFA, BREAK_CODE=8'hF0.
  - FRAME_BITS=11.
- One sub-module, ps2_line_sync: synchronizer plus falling-edge detect. It is reused by the PS2 receiver.

Test Plan:
- txData=0xED, device model clocks 11 edges and ACKs low -> ps2ClkLow high exactly 5001 cycles; line bits after start = 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; ready returns to 1.
- txData=0x07, device ACK bit driven high -> data bits 1,1,1,0,0,0,0,0, parity 0; ackError pulses; done stays 0; both lines released.
- txData=0xFF, device never clocks -> timeoutError pulses exactly TIMEOUT_CYCLES after SEND entry; ps2ClkLow=0 and ps2DataLow=0 afterwards.
- txStart asserted again during SEND with txData=0x00 -> ignored; in-flight 0xED frame completes unchanged; a single done pulse.
- rst asserted after 4th falling edge -> next cycle ps2ClkLow=0, ps2DataLow=0, ready=1, no done/error pulse; a subsequent 0xF4 frame completes normally.
- 1-cycle glitch on ps2ClkIn (shorter than the sync path) and SYNC_STAGES=3 -> bitCount advances only on real edges; frame and parity are still correct.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, keyboard
// command/response bytes, frame length and the frame parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SEND,
      WAIT_IDLE
   } ps2_state_e;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] BREAK_CODE   = 8'hF0;

   localparam int FRAME_BITS = 11;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock/data lines and flags clean falling clock edges.
// The clock level only changes once every synchronizer stage agrees, so short glitches never count as edges.
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2Clk_i,
   input  logic ps2Data_i,
   output logic clkLevel_o,
   output logic dataLevel_o,
   output logic fallEdge_o
);

   logic [SYNC_STAGES-1:0] clkSh_q;
   logic [SYNC_STAGES-1:0] dataSh_q;
   logic                   clkLvl_q;
   logic                   fall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         clkSh_q  <= '1;
         dataSh_q <= '1;
         clkLvl_q <= 1'b1;
         fall_q   <= 1'b0;
      end else begin
         clkSh_q  <= {clkSh_q[SYNC_STAGES-2:0], ps2Clk_i};
         dataSh_q <= {dataSh_q[SYNC_STAGES-2:0], ps2Data_i};
         fall_q   <= 1'b0;
         if (clkLvl_q && (clkSh_q == '0)) begin
            clkLvl_q <= 1'b0;
            fall_q   <= 1'b1;
         end else if (clkSh_q == '1) begin
            clkLvl_q <= 1'b1;
         end
      end
   end

   assign clkLevel_o  = clkLvl_q;
   assign dataLevel_o = dataSh_q[SYNC_STAGES-1];
   assign fallEdge_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts one
// command byte out on device clock edges and checks the device's ACK bit.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] txData,
   input  logic       txStart,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       ackError,
   output logic       timeoutError,
   input  logic       ps2ClkIn,
   input  logic       ps2DataIn,
   output logic       ps2ClkLow,
   output logic       ps2DataLow
);
   import ps2_pkg::*;

   localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int CNT_W = (INH_W > TO_W) ? INH_W : TO_W;
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       ACK_BIT_PREV = 4'(FRAME_BITS - 1);

   ps2_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bitCnt_q, bitCnt_d;
   logic [7:0]       data_q, data_d;
   logic             parity_q, parity_d;
   logic             evDone, evAck, evTo;
   logic             clkLvl, dataLvl, fallEdge;

   logic ready_q, ready_d, busy_q, busy_d, done_q, done_d;
   logic ackErr_q, ackErr_d, toErr_q, toErr_d, clkLow_q, clkLow_d, dataLow_q, dataLow_d;

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk         (clk),
      .rst         (rst),
      .ps2Clk_i    (ps2ClkIn),
      .ps2Data_i   (ps2DataIn),
      .clkLevel_o  (clkLvl),
      .dataLevel_o (dataLvl),
      .fallEdge_o  (fallEdge)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bitCnt_q  <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ackErr_q  <= 1'b0;
         toErr_q   <= 1'b0;
         clkLow_q  <= 1'b0;
         dataLow_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bitCnt_q  <= bitCnt_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ackErr_q  <= ackErr_d;
         toErr_q   <= toErr_d;
         clkLow_q  <= clkLow_d;
         dataLow_q <= dataLow_d;
      end
      data_q   <= data_d;
      parity_q <= parity_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitCnt_d = bitCnt_q;
      data_d   = data_q;
      parity_d = parity_q;
      evDone   = 1'b0;
      evAck    = 1'b0;
      evTo     = 1'b0;
      case (state_q)
         IDLE: begin
            if (txStart) begin
               data_d   = txData;
               parity_d = odd_parity(txData);
               cnt_d    = '0;
               bitCnt_d = '0;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == INH_LAST) state_d = RTS;
         end
         RTS: begin
            cnt_d   = '0;
            state_d = SEND;
         end
         SEND, WAIT_IDLE: begin
            cnt_d = cnt_q + 1'b1;
            // Timeout wins over any edge or idle detection in the same cycle
            if (cnt_q == TO_LAST) begin
               evTo    = 1'b1;
               state_d = IDLE;
            end else if (state_q == SEND) begin
               if (fallEdge) begin
                  bitCnt_d = bitCnt_q + 1'b1;
                  if (bitCnt_q == ACK_BIT_PREV) begin
                     if (dataLvl) begin
                        evAck   = 1'b1;
                        state_d = IDLE;
                     end else begin
                        state_d = WAIT_IDLE;
                     end
                  end
               end
            end else if (clkLvl && dataLvl) begin
               evDone  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_d   = (state_d == IDLE);
      busy_d    = (state_d != IDLE);
      done_d    = evDone;
      ackErr_d  = evAck;
      toErr_d   = evTo;
      clkLow_d  = (state_d == INHIBIT) || (state_d == RTS);
      dataLow_d = 1'b0;
      case (state_d)
         RTS: dataLow_d = 1'b1;
         SEND: begin
            // Entering SEND keeps data low as the start bit
            if (state_q != SEND) begin
               dataLow_d = 1'b1;
            end else if (fallEdge) begin
               if (bitCnt_d <= 4'd8)      dataLow_d = ~data_q[3'(bitCnt_d - 4'd1)];
               else if (bitCnt_d == 4'd9) dataLow_d = ~parity_q;
               else                       dataLow_d = 1'b0;
            end else begin
               dataLow_d = dataLow_q;
            end
         end
         default: dataLow_d = 1'b0;
      endcase
   end

   assign ready        = ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign ackError     = ackErr_q;
   assign timeoutError = toErr_q;
   assign ps2ClkLow    = clkLow_q;
   assign ps2DataLow   = dataLow_q;

endmodule
